// File: rtl/im_loader_if.sv
// Loader control, byte stream and instruction-memory write bundle.
// master drives start/stream (host side); slave is the loader.
interface im_loader_if #(
  parameter int AW = 8
);
  logic          start;
  logic [AW:0]   word_count;
  logic          in_valid;
  logic [7:0]    in_data;
  logic          in_ready;
  logic          we;
  logic [31:0]   waddr;
  logic [31:0]   wdata;
  logic          busy;
  logic          cpu_hold;
  logic          done;
  logic          err;

  modport master (
    output start, word_count, in_valid, in_data,
    input  in_ready, we, waddr, wdata, busy, cpu_hold, done, err
  );

  modport slave (
    input  start, word_count, in_valid, in_data,
    output in_ready, we, waddr, wdata, busy, cpu_hold, done, err
  );
endinterface

// File: rtl/im_loader.sv
// Packs a big-endian byte stream into 32-bit words and writes them to instruction memory from 0.
// 5 cycles/word minimum (4 accepts + 1 write); in_ready drops during the write cycle, stalls freely on in_valid.
module im_loader #(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  im_loader_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RECV, WRITE, DONE} state_t;

  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  state_t        state;
  logic [AW:0]   cnt;
  logic [AW-1:0] widx;
  logic [1:0]    bcnt;
  logic [23:0]   shreg;
  logic          last_word;

  assign last_word = ({1'b0, widx} == (cnt - 1'b1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      widx         <= '0;
      bcnt         <= '0;
      shreg        <= '0;
      bus.in_ready <= 1'b0;
      bus.we       <= 1'b0;
      bus.waddr    <= '0;
      bus.wdata    <= '0;
      bus.busy     <= 1'b0;
      bus.cpu_hold <= 1'b0;
      bus.done     <= 1'b0;
      bus.err      <= 1'b0;
    end else begin
      bus.we   <= 1'b0;
      bus.done <= 1'b0;
      bus.err  <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            if (bus.word_count != '0 && bus.word_count <= DEPTH_W) begin
              cnt          <= bus.word_count;
              widx         <= '0;
              bcnt         <= '0;
              shreg        <= '0;
              bus.in_ready <= 1'b1;
              bus.busy     <= 1'b1;
              bus.cpu_hold <= 1'b1;
              state        <= RECV;
            end else begin
              bus.err <= 1'b1;
            end
          end
        end
        RECV: begin
          if (bus.in_valid && bus.in_ready) begin
            // Earlier bytes shift up, so the first byte lands in the MSB.
            if (bcnt == 2'd3) begin
              bus.wdata    <= {shreg, bus.in_data};
              bus.waddr    <= 32'(widx);
              bus.we       <= 1'b1;
              bus.in_ready <= 1'b0;
              state        <= WRITE;
            end else begin
              shreg <= {shreg[15:0], bus.in_data};
              bcnt  <= bcnt + 2'd1;
            end
          end
        end
        WRITE: begin
          if (last_word) begin
            bus.done <= 1'b1;
            state    <= DONE;
          end else begin
            widx         <= widx + 1'b1;
            bcnt         <= '0;
            bus.in_ready <= 1'b1;
            state        <= RECV;
          end
        end
        DONE: begin
          bus.busy     <= 1'b0;
          bus.cpu_hold <= 1'b0;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_im_loader.sv
// Scoreboard bench for im_loader: expected writes queued at stimulus time, checked as we pulses appear.
module tb_im_loader;
  localparam int DEPTH = 256;
  localparam int AW    = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  im_loader_if #(.AW(AW)) bus();

  im_loader #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int pass_cnt = 0;
  int tot_cnt  = 0;

  logic [63:0] exp_q[$];
  logic [63:0] exp_w;
  int  we_cnt      = 0;
  int  done_cnt    = 0;
  int  err_cnt     = 0;
  int  cyc         = 0;
  int  last_we_cyc = -10;
  bit  done_prev   = 1'b0;

  // Output monitor: pops the scoreboard on every write and checks done/busy timing.
  always @(negedge clk) begin
    cyc++;
    if (bus.we === 1'b1) begin
      we_cnt++;
      last_we_cyc = cyc;
      tot_cnt++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_write waddr=%h wdata=%h required no write", bus.waddr, bus.wdata);
      end else begin
        exp_w = exp_q.pop_front();
        if ({bus.waddr, bus.wdata} !== exp_w)
          $display("FAIL write_data waddr=%h wdata=%h required waddr=%h wdata=%h",
                   bus.waddr, bus.wdata, exp_w[63:32], exp_w[31:0]);
        else
          pass_cnt++;
      end
    end
    if (bus.done === 1'b1) begin
      done_cnt++;
      tot_cnt++;
      if ({bus.busy, bus.cpu_hold, (last_we_cyc == cyc - 1)} !== 3'b111)
        $display("FAIL done_timing busy=%b cpu_hold=%b we_to_done=%0d required 1 1 1",
                 bus.busy, bus.cpu_hold, cyc - last_we_cyc);
      else
        pass_cnt++;
    end
    if (done_prev) begin
      tot_cnt++;
      if ({bus.busy, bus.cpu_hold} !== 2'b00)
        $display("FAIL busy_after_done busy=%b cpu_hold=%b required 0 0", bus.busy, bus.cpu_hold);
      else
        pass_cnt++;
    end
    done_prev = (bus.done === 1'b1);
    if (bus.err === 1'b1) err_cnt++;
  end

  task automatic do_start(input logic [AW:0] cnt);
    bus.start      = 1'b1;
    bus.word_count = cnt;
    @(negedge clk);
    bus.start      = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    while (bus.in_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      tot_cnt++;
      $display("FAIL byte_accept_timeout in_ready=%b required 1", bus.in_ready);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int gap);
    logic [31:0] wv;
    wv = w;
    for (int k = 0; k < 4; k++) begin
      send_byte(wv[31-8*k -: 8]);
      for (int g = 0; g < gap; g++) begin
        if (k != 3) begin
          tot_cnt++;
          if (bus.in_ready !== 1'b1)
            $display("FAIL ready_in_gap in_ready=%b required 1", bus.in_ready);
          else
            pass_cnt++;
        end
        @(negedge clk);
      end
    end
  endtask

  task automatic wait_done(input int base);
    int n;
    n = 0;
    while (done_cnt == base && n < 100) begin
      @(negedge clk);
      n++;
    end
    tot_cnt++;
    if (done_cnt == base) $display("FAIL done_timeout done_cnt=%0d required >%0d", done_cnt, base);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    tot_cnt++;
    if ({bus.we, bus.done, bus.err, bus.in_ready, bus.busy, bus.cpu_hold} !== 6'b0)
      $display("FAIL reset_ctrl we/done/err/rdy/busy/hold=%b required 000000",
               {bus.we, bus.done, bus.err, bus.in_ready, bus.busy, bus.cpu_hold});
    else pass_cnt++;
    tot_cnt++;
    if ({bus.waddr, bus.wdata} !== 64'd0)
      $display("FAIL reset_bus waddr=%h wdata=%h required 0 0", bus.waddr, bus.wdata);
    else pass_cnt++;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic run_basic(input int gap);
    int w0, d0, e0;
    w0 = we_cnt; d0 = done_cnt; e0 = err_cnt;
    exp_q.push_back({32'd0, 32'h20010005});
    exp_q.push_back({32'd1, 32'h8C220004});
    do_start(9'd2);
    send_word(32'h20010005, gap);
    send_word(32'h8C220004, gap);
    wait_done(d0);
    repeat (2) @(negedge clk);
    tot_cnt++;
    if (we_cnt - w0 != 2) $display("FAIL basic_write_count gap=%0d got=%0d required 2", gap, we_cnt - w0);
    else pass_cnt++;
    tot_cnt++;
    if (done_cnt - d0 != 1 || err_cnt != e0)
      $display("FAIL basic_done_err gap=%0d done=%0d err=%0d required 1 0", gap, done_cnt - d0, err_cnt - e0);
    else pass_cnt++;
    tot_cnt++;
    if (exp_q.size() != 0) $display("FAIL basic_missing_writes left=%0d required 0", exp_q.size());
    else pass_cnt++;
  endtask

  task automatic test_basic();
    run_basic(0);
  endtask

  task automatic test_backpressure();
    run_basic(3);
  endtask

  task automatic test_reject();
    int w0, d0, e0;
    logic [AW:0] bad[2];
    w0 = we_cnt; d0 = done_cnt; e0 = err_cnt;
    bad[0] = '0;
    bad[1] = (AW+1)'(DEPTH + 1);
    for (int i = 0; i < 2; i++) begin
      do_start(bad[i]);
      tot_cnt++;
      if ({bus.err, bus.busy, bus.in_ready} !== 3'b100)
        $display("FAIL reject_err cnt=%0d err/busy/rdy=%b required 100", bad[i], {bus.err, bus.busy, bus.in_ready});
      else pass_cnt++;
      @(negedge clk);
      tot_cnt++;
      if ({bus.err, bus.busy} !== 2'b00)
        $display("FAIL reject_pulse cnt=%0d err/busy=%b required 00", bad[i], {bus.err, bus.busy});
      else pass_cnt++;
    end
    tot_cnt++;
    if (err_cnt - e0 != 2 || we_cnt != w0 || done_cnt != d0)
      $display("FAIL reject_counts err=%0d we=%0d done=%0d required 2 0 0", err_cnt - e0, we_cnt - w0, done_cnt - d0);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    int w0, d0;
    w0 = we_cnt;
    do_start(9'd1);
    send_byte(8'h11);
    send_byte(8'h22);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tot_cnt++;
    if (we_cnt != w0 || {bus.busy, bus.in_ready} !== 2'b00)
      $display("FAIL reset_mid_abort we=%0d busy/rdy=%b required 0 00", we_cnt - w0, {bus.busy, bus.in_ready});
    else pass_cnt++;
    @(negedge clk);
    d0 = done_cnt;
    exp_q.push_back({32'd0, 32'hAABBCCDD});
    do_start(9'd1);
    send_word(32'hAABBCCDD, 0);
    wait_done(d0);
    @(negedge clk);
    tot_cnt++;
    if (we_cnt - w0 != 1 || exp_q.size() != 0)
      $display("FAIL reset_mid_writes we=%0d left=%0d required 1 0", we_cnt - w0, exp_q.size());
    else pass_cnt++;
  endtask

  task automatic test_start_busy();
    int w0, d0, e0;
    w0 = we_cnt; d0 = done_cnt; e0 = err_cnt;
    exp_q.push_back({32'd0, 32'h01020304});
    do_start(9'd1);
    send_byte(8'h01);
    send_byte(8'h02);
    do_start(9'd5);
    send_byte(8'h03);
    send_byte(8'h04);
    wait_done(d0);
    repeat (3) @(negedge clk);
    tot_cnt++;
    if (we_cnt - w0 != 1 || done_cnt - d0 != 1 || err_cnt != e0)
      $display("FAIL start_busy we=%0d done=%0d err=%0d required 1 1 0", we_cnt - w0, done_cnt - d0, err_cnt - e0);
    else pass_cnt++;
    tot_cnt++;
    if ({bus.busy, bus.in_ready} !== 2'b00)
      $display("FAIL start_busy_restart busy/rdy=%b required 00", {bus.busy, bus.in_ready});
    else pass_cnt++;
  endtask

  task automatic test_full_depth();
    int w0, d0, hold_bad;
    w0 = we_cnt; d0 = done_cnt; hold_bad = 0;
    for (int i = 0; i < DEPTH; i++) exp_q.push_back({32'(i), 32'(i)});
    do_start((AW+1)'(DEPTH));
    for (int i = 0; i < DEPTH; i++) begin
      if (bus.cpu_hold !== 1'b1) hold_bad++;
      send_word(32'(i), 0);
    end
    tot_cnt++;
    if (hold_bad != 0) $display("FAIL full_cpu_hold low_words=%0d required 0", hold_bad);
    else pass_cnt++;
    wait_done(d0);
    @(negedge clk);
    tot_cnt++;
    if (we_cnt - w0 != DEPTH || exp_q.size() != 0)
      $display("FAIL full_write_count we=%0d left=%0d required %0d 0", we_cnt - w0, exp_q.size(), DEPTH);
    else pass_cnt++;
  endtask

  initial begin
    bus.start      = 1'b0;
    bus.word_count = '0;
    bus.in_valid   = 1'b0;
    bus.in_data    = '0;
    test_reset();
    test_basic();
    test_backpressure();
    test_reject();
    test_reset_mid();
    test_start_busy();
    test_full_depth();
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end
endmodule

// File: doc/im_loader.md
Name: im_loader

Overview:
- Writer-side companion to the instruction memory.
- Accepts a byte stream over a valid/ready handshake, packs it big-endian into 32-bit instruction words and drives the instruction memory write port at consecutive word addresses from 0.
- Holds the CPU off fetch while a load is in progress.
- Used at bring-up to program the instruction memory instead of a preloaded hex file.

Parameters:
- DEPTH, 256, number of 32-bit words in the instruction memory.
- AW, 8, word-address width; must satisfy 2^AW >= DEPTH.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on rising clk edge.
- start  input  1  single-cycle request to begin a load; sampled only in IDLE.
- word_count  input  AW+1  number of words to load; latched when start is accepted.
- in_valid  input  1  byte on in_data is valid.
- in_data  input  8  stream byte.
- in_ready  output  1  loader accepts a byte this cycle.
- we  output  1  instruction memory write enable, one cycle per word.
- waddr  output  32  word address (word index, same indexing the fetch side uses); upper bits zero.
- wdata  output  32  assembled instruction word.
- busy  output  1  load in progress.
- cpu_hold  output  1  stall request to fetch/PC logic; equals busy.
- done  output  1  one-cycle pulse after the last word is written.
- err  output  1  one-cycle pulse when start is rejected.

Behaviour:
- Reset, rst_n=0 at an edge:
  - state=IDLE; we, done, err, in_ready, busy, cpu_hold all 0.
  - waddr=0, wdata=0, byte counter=0, word index=0.
  - Any partial word is discarded. Reset applies mid-load with no further write.
- States: IDLE, RECV, WRITE, DONE.
- IDLE:
  - in_ready=0.
  - start=1 with 1 <= word_count <= DEPTH: latch count, clear word index and byte counter, go to RECV.
  - start=1 with word_count=0 or word_count>DEPTH: err=1 next cycle, stay IDLE.
  - start=0: remain in IDLE.
- RECV:
  - in_ready=1.
  - A byte is accepted when in_valid & in_ready at the edge.
  - Byte k (k=0..3) goes to wdata[31-8k -: 8]; the first byte is the MSB.
  - The byte counter advances only on acceptance. in_valid low inserts wait cycles indefinitely with no timeout.
  - Accepting the 4th byte moves to WRITE.
- WRITE (exactly one cycle):
  - in_ready=0, we=1, waddr=word index, wdata=assembled word.
  - If word index = count-1, go to DONE. Otherwise increment word index, clear the byte counter and go to RECV.
- DONE (one cycle): done=1, busy=1. Then go to IDLE.
- busy and cpu_hold are 1 in RECV, WRITE and DONE; they deassert the cycle after done.
- start while not in IDLE is ignored: no restart, no err.
- Timing:
  - Minimum throughput is 5 cycles per word: 4 accept cycles plus 1 write cycle.
  - we rises the cycle after the 4th byte is accepted.
- waddr holds its last written value outside WRITE; we is the only qualifier.
- The word index never exceeds count-1, so there is no wrap.

Test Plan:
- Basic load, back-to-back bytes:
  - Stimulus: start, word_count=2, bytes 20 01 00 05 8C 22 00 04.
  - Required: we pulses carry waddr=0 wdata=0x20010005, then waddr=1 wdata=0x8C220004.
  - Required: exactly 2 writes; done pulses once, 1 cycle after the 2nd write; busy deasserts the cycle after done.
- Backpressure gaps:
  - Stimulus: same stream with in_valid low 3 cycles between every byte.
  - Required: identical writes and data; in_ready stays 1 through the gaps; no extra we.
- Rejection:
  - Stimulus: word_count=0, then word_count=DEPTH+1.
  - Required: err=1 for one cycle each; busy, we and done stay 0; loader remains in IDLE.
- Reset mid-word:
  - Stimulus: start with count=1; accept 2 bytes; hold rst_n low 1 cycle; new start with count=1 and bytes AA BB CC DD.
  - Required: no write before reset; single write waddr=0 wdata=0xAABBCCDD.
- Start while busy:
  - Stimulus: assert start with word_count=5 during RECV of a count=1 load.
  - Required: ignored; exactly 1 write, then done; no err.
- Full depth:
  - Stimulus: word_count=256, word i = i.
  - Required: 256 writes at waddr 0..255 with wdata=i; done after waddr=255; cpu_hold high throughout.
